// File: rtl/ptr_sync_pkg.sv
// Shared constants and helpers for the Gray pointer synchronizer.
// The optional gray-error checker is enabled by PTR_SYNC_GRAY_ERR_CHECK_EN (see ptr_sync_gray).
package ptr_sync_pkg;

    localparam int PTR_SYNC_MIN_STAGES = 2;
    localparam int PTR_SYNC_MAX_STAGES = 4;
    localparam int PTR_SYNC_MIN_WIDTH  = 2;
    localparam int PTR_SYNC_MAX_WIDTH  = 16;

    // Gray to binary at the widest supported width; narrower pointers are
    // zero-extended, which leaves the low bits of the result unchanged.
    function automatic logic [PTR_SYNC_MAX_WIDTH-1:0] gray_to_bin(
        input logic [PTR_SYNC_MAX_WIDTH-1:0] gray
    );
        logic [PTR_SYNC_MAX_WIDTH-1:0] bin;
        bin = '0;
        bin[PTR_SYNC_MAX_WIDTH-1] = gray[PTR_SYNC_MAX_WIDTH-1];
        for (int i = PTR_SYNC_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync_gray_sync_bit_chain.sv
// Single-bit synchronizer: STAGES flops back to back, nothing in between.
module sync_bit_chain
    import ptr_sync_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    if (STAGES < PTR_SYNC_MIN_STAGES || STAGES > PTR_SYNC_MAX_STAGES) begin : g_bad_stages
        $error("sync_bit_chain: STAGES=%0d outside legal range", STAGES);
    end

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; async clear on reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray.sv
// Gray-coded pointer synchronizer with registered binary decode, wrapping
// advance (ptr_delta) and a one-cycle change pulse.
// Define PTR_SYNC_GRAY_ERR_CHECK_EN to build the sticky multi-bit-change
// checker (gray_err / err_clr); otherwise gray_err is tied low.
module ptr_sync_gray
    import ptr_sync_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] async_gray,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sync_gray,
    output logic [WIDTH-1:0] sync_bin,
    output logic [WIDTH-1:0] ptr_delta,
    output logic             ptr_changed,
    output logic             gray_err
);

    if (WIDTH < PTR_SYNC_MIN_WIDTH || WIDTH > PTR_SYNC_MAX_WIDTH) begin : g_bad_width
        $error("ptr_sync_gray: WIDTH=%0d outside legal range", WIDTH);
    end
    if (STAGES < PTR_SYNC_MIN_STAGES || STAGES > PTR_SYNC_MAX_STAGES) begin : g_bad_stages
        $error("ptr_sync_gray: STAGES=%0d outside legal range", STAGES);
    end

    // Synchronizer stage: every bit crosses through its own chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        sync_bit_chain #(.STAGES(STAGES)) u_chain (
            .CLK (CLK),
            .RST (RST),
            .d   (async_gray[i]),
            .q   (sync_gray[i])
        );
    end

    // Decode stage: binary value of the synchronized pointer.
    logic [WIDTH-1:0] bin_next;
    logic             bin_upd;
    logic             primed;

    assign bin_next = WIDTH'(gray_to_bin(PTR_SYNC_MAX_WIDTH'(sync_gray)));
    assign bin_upd  = (bin_next != sync_bin);

    // Register the decode; the first change after reset only primes and reports zero advance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bin    <= '0;
            ptr_delta   <= '0;
            ptr_changed <= 1'b0;
            primed      <= 1'b0;
        end else begin
            ptr_changed <= bin_upd;
            if (bin_upd) begin
                sync_bin  <= bin_next;
                ptr_delta <= primed ? (bin_next - sync_bin) : '0;
                primed    <= 1'b1;
            end
        end
    end

`ifdef PTR_SYNC_GRAY_ERR_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] gray_diff;
    logic             multi_bit;

    assign gray_diff = sync_gray ^ prev_gray;
    assign multi_bit = |(gray_diff & (gray_diff - WIDTH'(1)));

    // Sticky error on any multi-bit step; a new error wins over a clear on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_gray <= '0;
            gray_err  <= 1'b0;
        end else begin
            prev_gray <= sync_gray;
            if (primed && multi_bit) begin
                gray_err <= 1'b1;
            end else if (err_clr) begin
                gray_err <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign gray_err       = 1'b0;
`endif

endmodule
